i2s_tx_ctrl: RTL and testbench
==============================

Name: i2s_tx_ctrl

Overview:
- Sample scheduler between the audio sample stream (stereo pairs, valid/ready) and the I2S transmitter's read port (rd_en / rd_valid / l_sample / r_sample).
- Prefetches one stereo pair into a holding register and answers every transmitter read within one cycle, with real data or silence, so the serial link never stalls.
- Sequences start-up, orderly drain on disable, and mute.
- Counts and flags underruns for the control/status block.

Parameters:
DW  24  sample width in bits; must equal the transmitter's DW
CW  16  underrun counter width

Ports:
clk             in   1    system clock (MCLK domain, same clock as the I2S clock generator and transmitter)
rst             in   1    synchronous, active-high reset
enable          in   1    level; 1 = run, 0 = drain then idle
mute            in   1    level; 1 = replace delivered samples with zero
s_l             in   DW   left sample of the incoming pair
s_r             in   DW   right sample of the incoming pair
s_valid         in   1    pair valid
s_ready         out  1    pair accepted when s_valid && s_ready
rd_en           in   1    one-cycle read strobe from the transmitter, one per frame
rd_early        in   1    one-cycle pre-frame strobe from the I2S clock generator; precedes rd_en
l_sample        out  DW   left sample to the transmitter
r_sample        out  DW   right sample to the transmitter
rd_valid        out  1    one-cycle strobe, asserted the cycle after rd_en
running         out  1    1 in RUN or DRAIN
underrun        out  1    one-cycle pulse per underrun
underrun_warn   out  1    one-cycle pulse, asserted the cycle after rd_early when hold is empty in RUN
underrun_count  out  CW   saturating underrun count; cleared only by rst

Behaviour:
- Reset values: state=IDLE; hold_valid=0; hold_l=hold_r=0; s_ready=0; l_sample=r_sample=0; rd_valid=0; running=0; underrun=0; underrun_warn=0; underrun_count=0.
- Holding register: one entry, {hold_l, hold_r, hold_valid}. No bypass path: a pair accepted in cycle N can be delivered at the earliest for an rd_en in cycle N+1.
- s_ready is combinational: (state==PRIME || state==RUN) && !hold_valid. On accept, hold is loaded and hold_valid=1.
- Every rd_en, in any state, produces rd_valid=1 exactly one cycle later. l_sample/r_sample are registered together with rd_valid, and hold their value until the next rd_valid.
- Delivered data on a read:
  - If hold_valid=1 and state is RUN, PRIME or DRAIN: output = mute ? 0 : hold contents; hold_valid is cleared in the same cycle.
  - Otherwise: output = 0.
- Underrun condition: rd_en in RUN with hold_valid=0.
  - Outputs zero.
  - underrun pulses in the cycle rd_valid is asserted.
  - underrun_count increments, saturating at 2^CW-1.
  - State stays RUN; no recovery handshake.
- Simultaneous rd_en with an accept into an empty hold: counts as an underrun and outputs zero; the accepted pair is delivered on the next rd_en.
- Simultaneous rd_en with hold_valid=1: the read consumes the hold; s_ready becomes 1 from the next cycle.
- underrun_warn is informational only; it does not count as an underrun.
- State machine:
  - IDLE: running=0, s_ready=0. enable=1 -> PRIME.
  - PRIME: waiting for the first pair. Reads answer zero and are not counted as underruns.
    - A read with hold_valid=1 delivers the pair -> RUN.
    - enable=0 -> IDLE; hold_valid is cleared (any primed pair is discarded).
  - RUN: normal streaming. enable=0 -> DRAIN.
  - DRAIN: s_ready=0; reads with hold_valid=0 are not counted as underruns.
    - The pending hold is delivered by the next read; when hold_valid=0 -> IDLE.
    - enable=1 while in DRAIN -> RUN.
- mute affects delivered data only; the stream is still consumed at the frame rate.
- rst mid-operation: next cycle all reset values apply. The held pair is discarded; a pending rd_valid is cancelled.
- l_sample and r_sample always change together (atomic stereo pair).

Test Plan:
- Reset: rst=1 for 3 cycles with s_valid=1 -> s_ready=0, rd_valid=0, underrun_count=0, state IDLE.
- Start-up: enable=1; pair L=24'h123456, R=24'hABCDEF presented before the first rd_en -> first rd_valid carries exactly those values; running=1 afterwards; count stays 0.
- Steady stream: 8 pairs 1..8, one per frame, FS_RATIO=256 -> 8 rd_valid strobes in order 1..8, 257 cycles apart, no underrun.
- Underrun: hold s_valid=0 across two frames in RUN -> each frame gives underrun_warn after rd_early, then rd_valid with 0/0 and an underrun pulse; count=2. Resuming s_valid -> next frame delivers data.
- Mute/drain: mute=1 for pair 24'h7FFFFF -> 0/0 output and the pair is consumed. Then drop enable with one pair held -> that pair is delivered, then IDLE, running=0, s_ready=0, no underrun counted.
- Edge cases:
  - Accept into an empty hold in the same cycle as rd_en -> zero output, count+1, pair delivered next frame.
  - Counter with CW=2 after 5 underruns -> count=3 (saturated).

Source files
------------

// File: rtl/i2s_tx_ctrl.sv
// Sample scheduler: prefetches one stereo pair and answers every transmitter read.
// Latency: rd_valid/l_sample/r_sample one cycle after rd_en; accepted pair readable from the next cycle.
// Backpressure: s_ready only in PRIME/RUN with an empty hold; reads are never stalled (zero on underrun).
module i2s_tx_ctrl #(
    parameter int DW = 24,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          mute,
    input  logic [DW-1:0] s_l,
    input  logic [DW-1:0] s_r,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          rd_en,
    input  logic          rd_early,
    output logic [DW-1:0] l_sample,
    output logic [DW-1:0] r_sample,
    output logic          rd_valid,
    output logic          running,
    output logic          underrun,
    output logic          underrun_warn,
    output logic [CW-1:0] underrun_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          hold_valid;
    logic [DW-1:0] hold_l;
    logic [DW-1:0] hold_r;
    logic          accept;
    logic          deliver;
    logic          underrun_cond;
    logic          warn_cond;

    always_comb begin
        s_ready       = ((state == PRIME) || (state == RUN)) && !hold_valid;
        accept        = s_valid && s_ready;
        deliver       = rd_en && hold_valid && (state != IDLE);
        underrun_cond = rd_en && (state == RUN) && !hold_valid;
        warn_cond     = rd_early && (state == RUN) && !hold_valid;
        running       = (state == RUN) || (state == DRAIN);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enable) state_nxt = PRIME;
            end
            PRIME: begin
                if (!enable)      state_nxt = IDLE;
                else if (deliver) state_nxt = RUN;
            end
            RUN: begin
                if (!enable) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (enable)           state_nxt = RUN;
                else if (!hold_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid     <= 1'b0;
            hold_l         <= '0;
            hold_r         <= '0;
            l_sample       <= '0;
            r_sample       <= '0;
            rd_valid       <= 1'b0;
            underrun       <= 1'b0;
            underrun_warn  <= 1'b0;
            underrun_count <= '0;
        end else begin
            // Leaving PRIME discards anything primed, including a pair accepted this cycle.
            if ((state == PRIME) && !enable) begin
                hold_valid <= 1'b0;
            end else if (accept) begin
                hold_l     <= s_l;
                hold_r     <= s_r;
                hold_valid <= 1'b1;
            end else if (deliver) begin
                hold_valid <= 1'b0;
            end

            rd_valid <= rd_en;
            if (rd_en) begin
                l_sample <= (deliver && !mute) ? hold_l : '0;
                r_sample <= (deliver && !mute) ? hold_r : '0;
            end

            underrun      <= underrun_cond;
            underrun_warn <= warn_cond;
            if (underrun_cond && (underrun_count != '1)) begin
                underrun_count <= underrun_count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Directed bench for i2s_tx_ctrl; CW=2 so counter saturation is reachable.
module tb_i2s_tx_ctrl;
    localparam int DW = 24;
    localparam int CW = 2;
    localparam int FS = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          mute;
    logic [DW-1:0] s_l;
    logic [DW-1:0] s_r;
    logic          s_valid;
    logic          s_ready;
    logic          rd_en;
    logic          rd_early;
    logic [DW-1:0] l_sample;
    logic [DW-1:0] r_sample;
    logic          rd_valid;
    logic          running;
    logic          underrun;
    logic          underrun_warn;
    logic [CW-1:0] underrun_count;

    int errors = 0;
    int checks = 0;

    i2s_tx_ctrl #(.DW(DW), .CW(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .mute           (mute),
        .s_l            (s_l),
        .s_r            (s_r),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .rd_en          (rd_en),
        .rd_early       (rd_early),
        .l_sample       (l_sample),
        .r_sample       (r_sample),
        .rd_valid       (rd_valid),
        .running        (running),
        .underrun       (underrun),
        .underrun_warn  (underrun_warn),
        .underrun_count (underrun_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one pair and wait (bounded) until it is accepted.
    task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r, input string tag);
        bit done = 0;
        s_l     = l;
        s_r     = r;
        s_valid = 1'b1;
        for (int i = 0; i < 8 && !done; i++) begin
            if (s_ready) done = 1;
            tick();
        end
        s_valid = 1'b0;
        if (!done) chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
    endtask

    // One frame of FS cycles: rd_early, three idle cycles, rd_en, then idle.
    task automatic frame(input logic [DW-1:0] el, input logic [DW-1:0] er,
                         input logic eu, input logic ew, input string tag);
        rd_early = 1'b1;
        tick();
        rd_early = 1'b0;
        chk({tag, "_warn"}, 32'(underrun_warn), 32'(ew));
        repeat (3) tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd1);
        chk({tag, "_l"}, 32'(l_sample), 32'(el));
        chk({tag, "_r"}, 32'(r_sample), 32'(er));
        chk({tag, "_underrun"}, 32'(underrun), 32'(eu));
        tick();
        chk({tag, "_rd_valid_pulse"}, 32'(rd_valid), 32'd0);
        chk({tag, "_underrun_pulse"}, 32'(underrun), 32'd0);
        repeat (FS - 6) tick();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; mute = 1'b0;
        s_l = '0; s_r = '0; s_valid = 1'b1;
        rd_en = 1'b0; rd_early = 1'b0;

        // Reset with s_valid held high
        repeat (3) tick();
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_count", 32'(underrun_count), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_l", 32'(l_sample), 32'd0);
        rst = 1'b0; s_valid = 1'b0;
        tick();
        chk("idle_s_ready", 32'(s_ready), 32'd0);

        // Start-up: first pair, PRIME reads are not underruns
        enable = 1'b1;
        tick();
        chk("prime_running", 32'(running), 32'd0);
        chk("prime_s_ready", 32'(s_ready), 32'd1);
        push(24'h123456, 24'hABCDEF, "start");
        frame(24'h123456, 24'hABCDEF, 1'b0, 1'b0, "start");
        chk("start_running", 32'(running), 32'd1);
        chk("start_count", 32'(underrun_count), 32'd0);

        // Steady stream of pairs 1..8
        for (int i = 1; i <= 8; i++) begin
            push(DW'(i), DW'(i + 16), $sformatf("stream%0d", i));
            frame(DW'(i), DW'(i + 16), 1'b0, 1'b0, $sformatf("stream%0d", i));
        end
        chk("stream_count", 32'(underrun_count), 32'd0);

        // Two starved frames in RUN
        frame(24'h0, 24'h0, 1'b1, 1'b1, "under1");
        frame(24'h0, 24'h0, 1'b1, 1'b1, "under2");
        chk("under_count", 32'(underrun_count), 32'd2);
        chk("under_running", 32'(running), 32'd1);
        push(24'h000055, 24'h000066, "resume");
        frame(24'h000055, 24'h000066, 1'b0, 1'b0, "resume");

        // Mute: pair consumed, silence delivered
        mute = 1'b1;
        push(24'h7FFFFF, 24'h7FFFFF, "mute");
        frame(24'h0, 24'h0, 1'b0, 1'b0, "mute");
        mute = 1'b0;
        chk("mute_consumed", 32'(s_ready), 32'd1);

        // Drain with one pair held
        push(24'h0000A1, 24'h0000B2, "drain");
        enable = 1'b0;
        tick();
        chk("drain_running", 32'(running), 32'd1);
        chk("drain_s_ready", 32'(s_ready), 32'd0);
        frame(24'h0000A1, 24'h0000B2, 1'b0, 1'b0, "drain");
        chk("drain_idle_running", 32'(running), 32'd0);
        chk("drain_idle_s_ready", 32'(s_ready), 32'd0);
        chk("drain_count", 32'(underrun_count), 32'd2);
        frame(24'h0, 24'h0, 1'b0, 1'b0, "idle_read");
        chk("idle_count", 32'(underrun_count), 32'd2);

        // Restart, then accept into empty hold in the same cycle as rd_en
        enable = 1'b1;
        tick();
        push(24'h000001, 24'h000002, "restart");
        frame(24'h000001, 24'h000002, 1'b0, 1'b0, "restart");
        rd_early = 1'b1;
        tick();
        rd_early = 1'b0;
        chk("simul_warn", 32'(underrun_warn), 32'd1);
        repeat (3) tick();
        s_l = 24'h0000C1; s_r = 24'h0000C2; s_valid = 1'b1; rd_en = 1'b1;
        chk("simul_s_ready", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0; rd_en = 1'b0;
        chk("simul_rd_valid", 32'(rd_valid), 32'd1);
        chk("simul_l", 32'(l_sample), 32'd0);
        chk("simul_underrun", 32'(underrun), 32'd1);
        chk("simul_count", 32'(underrun_count), 32'd3);
        chk("simul_hold_full", 32'(s_ready), 32'd0);
        repeat (FS - 6) tick();
        frame(24'h0000C1, 24'h0000C2, 1'b0, 1'b0, "simul_next");

        // Saturation: fourth and fifth underruns
        frame(24'h0, 24'h0, 1'b1, 1'b1, "sat4");
        frame(24'h0, 24'h0, 1'b1, 1'b1, "sat5");
        chk("sat_count", 32'(underrun_count), 32'd3);

        // Reset mid-operation cancels the pending read and clears everything
        s_l = 24'h0000EE; s_r = 24'h0000FF; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        rd_en = 1'b1; rst = 1'b1;
        tick();
        rd_en = 1'b0; rst = 1'b0;
        chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
        chk("midrst_count", 32'(underrun_count), 32'd0);
        chk("midrst_running", 32'(running), 32'd0);
        chk("midrst_l", 32'(l_sample), 32'd0);
        enable = 1'b0;
        tick();
        frame(24'h0, 24'h0, 1'b0, 1'b0, "midrst_read");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
